unsigned_mult_pipe: RTL and testbench
=====================================

Name: unsigned_mult_pipe

Overview:
- Pipelined unsigned integer multiplier: registers two WIDTH-bit operands, forms the full 2*WIDTH-bit product through an explicit partial-product adder array, and presents it registered.
- Default configuration is 5x5 -> 10 bits.
- Arithmetic leaf for datapath blocks that need a fixed-latency product and can stream one operand pair per clock.

Parameters:
- WIDTH, 5, operand width in bits; product is 2*WIDTH bits; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair on dataa/datab is valid this cycle.
- dataa  input  WIDTH  unsigned multiplicand.
- datab  input  WIDTH  unsigned multiplier.
- out_valid  output  1  dataout holds a valid product this cycle.
- dataout  output  2*WIDTH  unsigned product dataa*datab.

Behaviour:
- Reset: rst_n low asynchronously clears all pipeline registers.
  - dataout = 0 and out_valid = 0 immediately, held while rst_n is low.
  - First capture occurs on the first rising clk edge after rst_n deasserts.
- Stage 1 (edge N): dataa, datab and in_valid are registered unconditionally every cycle; no enable, no stall.
- Between stages, combinational logic:
  - WIDTH partial products pp[i] = (datab_r[i] ? dataa_r : 0) << i.
  - Reduced by a ripple/carry-save array of full and half adders to a 2*WIDTH-bit sum.
  - Must be built structurally from explicit adder cells, not a behavioural multiply operator.
- Stage 2 (edge N+1): sum registered into dataout; in_valid_r registered into out_valid.
- Latency: exactly 2 rising edges from operands to product.
  - Operands applied before edge N produce a result visible after edge N+1.
  - Throughput is 1 pair/cycle.
- dataout updates every cycle regardless of in_valid, so a combinational-equivalent check holds after 2 edges of stable inputs.
  - out_valid only qualifies the data; it does not gate it.
- Width rule: product is exact, never truncated or saturated.
  - Max value is (2^WIDTH-1)^2, i.e. 961 = 10'h3C1 for WIDTH=5.
- Inputs held constant: dataout remains stable at the same product indefinitely.
- Back-to-back different operands: each pair's product appears in consecutive cycles, in order, with no bubbles.
- Reset mid-operation: in-flight products are discarded; no stale product or out_valid pulse after reset release.
- X/Z on inputs is not required to be handled; all outputs are 2-state after reset.

Test Plan:
- Reset, then dataa=0, datab=0, in_valid=1 held 2 cycles -> dataout=0, out_valid=1; during reset dataout=0, out_valid=0.
- dataa=31, datab=31 -> dataout=961 two edges later; dataa=31, datab=1 -> 31; dataa=16, datab=2 -> 32; dataa=1, datab=31 -> 31.
- Stream 5 pairs back-to-back ((3,7),(5,5),(0,19),(31,2),(12,12)) -> products 21, 25, 0, 62, 144 on consecutive cycles starting 2 edges after the first pair.
- 100 random operand pairs, each held 2 cycles (change on falling edge, compare on the falling edge two cycles later) -> dataout equals reference a*b in every case; zero mismatches.
- Assert rst_n low between edges while a product is in flight -> dataout=0, out_valid=0 immediately; after release, no output until 2 edges past the first new operands.
- Toggle in_valid 1,0,1 with fixed operands 9, 9 -> dataout=81 continuously; out_valid follows pattern 1,0,1 delayed 2 cycles.

Source files
------------

// File: rtl/unsigned_mult_pipe.sv
// unsigned_mult_pipe: two-stage pipelined unsigned multiplier.
//   Stage 1 registers the operands and in_valid.
//   Between the stages an array of half/full adder cells reduces the
//   partial products to the full 2*WIDTH-bit product.
//   Stage 2 registers that product and the valid bit.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears every pipeline register
//   in_valid   dataa/datab carry a valid operand pair this cycle
//   dataa      WIDTH-bit unsigned multiplicand
//   datab      WIDTH-bit unsigned multiplier
//   out_valid  dataout holds a valid product (qualifier only, never gates data)
//   dataout    2*WIDTH-bit exact product, latency 2 edges

module mult_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module mult_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module unsigned_mult_pipe #(
  parameter int WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   dataa,
  input  logic [WIDTH-1:0]   datab,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] dataout
);
  localparam int STAGES = 2;

  logic [WIDTH-1:0]            dataa_r, datab_r;
  logic [STAGES:1]             vld_pipe;
  logic [2*WIDTH-1:0]          prod;
  logic [WIDTH-1:0]            pp0;
  // hi[r]: upper WIDTH bits of the running sum after row r; the low bit of
  // each row retires straight into the product.
  logic [WIDTH-2:0][WIDTH-1:0] hi;
  // t[r]: WIDTH+1-bit ripple sum of row r.
  logic [WIDTH-1:1][WIDTH:0]   t;

  assign pp0     = dataa_r & {WIDTH{datab_r[0]}};
  assign prod[0] = pp0[0];
  assign hi[0]   = {1'b0, pp0[WIDTH-1:1]};

  generate
    for (genvar r = 1; r < WIDTH; r++) begin : g_row
      logic [WIDTH-1:0] pp, c, acc_in;
      assign pp     = dataa_r & {WIDTH{datab_r[r]}};
      assign acc_in = hi[r-1];

      // Row LSB has no incoming carry.
      mult_ha u_ha (.a(acc_in[0]), .b(pp[0]), .s(t[r][0]), .c(c[0]));
      for (genvar b = 1; b < WIDTH; b++) begin : g_bit
        mult_fa u_fa (.a(acc_in[b]), .b(pp[b]), .ci(c[b-1]),
                      .s(t[r][b]), .co(c[b]));
      end
      // Both addends are < 2^WIDTH, so the carry-out is the sum's MSB.
      assign t[r][WIDTH] = c[WIDTH-1];
      assign prod[r]     = t[r][0];

      if (r < WIDTH-1) begin : g_pass
        assign hi[r] = t[r][WIDTH:1];
      end else begin : g_top
        assign prod[2*WIDTH-1:WIDTH] = t[r][WIDTH:1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataa_r  <= '0;
      datab_r  <= '0;
      vld_pipe <= '0;
      dataout  <= '0;
    end else begin
      dataa_r  <= dataa;
      datab_r  <= datab;
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      dataout  <= prod;
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_unsigned_mult_pipe.sv
module tb_unsigned_mult_pipe;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [W-1:0]   dataa, datab;
  logic           out_valid;
  logic [2*W-1:0] dataout;

  int errs   = 0;
  int checks = 0;

  typedef struct {
    int a;
    int b;
    int prod;
  } vec_t;

  unsigned_mult_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .dataa(dataa), .datab(datab),
    .out_valid(out_valid), .dataout(dataout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input logic v);
    dataa    = W'(a);
    datab    = W'(b);
    in_valid = v;
  endtask

  // Reference: exact product of two unsigned operands.
  function automatic int ref_mul(input int a, input int b);
    return a * b;
  endfunction

  vec_t tbl[4];
  vec_t strm[5];
  int   vpat[3];

  initial begin
    tbl[0]  = '{31, 31, 961};
    tbl[1]  = '{31,  1,  31};
    tbl[2]  = '{16,  2,  32};
    tbl[3]  = '{ 1, 31,  31};
    strm[0] = '{ 3,  7,  21};
    strm[1] = '{ 5,  5,  25};
    strm[2] = '{ 0, 19,   0};
    strm[3] = '{31,  2,  62};
    strm[4] = '{12, 12, 144};
    vpat    = '{1, 0, 1};

    // Reset held with nonzero operands and clocks running: outputs stay 0.
    rst_n = 1'b0;
    drive(31, 31, 1'b1);
    repeat (3) @(negedge clk);
    chk("reset_dataout", int'(dataout), 0);
    chk("reset_valid", int'(out_valid), 0);

    // Release, zero operands.
    rst_n = 1'b1;
    drive(0, 0, 1'b1);
    @(negedge clk);
    chk("post_reset_1edge_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("zero_dataout", int'(dataout), 0);
    chk("zero_valid", int'(out_valid), 1);

    // Table-driven boundary products, each held 2 cycles.
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].a, tbl[i].b, 1'b1);
      repeat (2) @(negedge clk);
      chk($sformatf("tbl%0d_dataout", i), int'(dataout), tbl[i].prod);
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), 1);
    end

    // Constant inputs: product stays put.
    drive(31, 31, 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hold%0d", i), int'(dataout), 961);
      @(negedge clk);
    end

    // Back-to-back stream, one product per cycle in order.
    for (int c = 0; c < 7; c++) begin
      if (c >= 2) begin
        chk($sformatf("stream%0d_dataout", c-2), int'(dataout), strm[c-2].prod);
        chk($sformatf("stream%0d_valid", c-2), int'(out_valid), 1);
      end
      if (c < 5) drive(strm[c].a, strm[c].b, 1'b1);
      else       drive(0, 0, 1'b0);
      @(negedge clk);
    end

    // Random pairs, each held 2 cycles.
    for (int i = 0; i < 100; i++) begin
      int a, b;
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(0, (1 << W) - 1));
      drive(a, b, 1'b1);
      repeat (2) @(negedge clk);
      chk($sformatf("rand%0d_%0dx%0d", i, a, b), int'(dataout), ref_mul(a, b));
    end

    // Asynchronous reset while a product is in flight.
    drive(31, 31, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_dataout", int'(dataout), 0);
    chk("midreset_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(6, 7, 1'b1);
    @(negedge clk);
    chk("release_1edge_dataout", int'(dataout), 0);
    chk("release_1edge_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("release_2edge_dataout", int'(dataout), 42);
    chk("release_2edge_valid", int'(out_valid), 1);

    // in_valid toggling with fixed operands: data unaffected, valid delayed 2.
    for (int c = 0; c < 5; c++) begin
      if (c >= 2) begin
        chk($sformatf("toggle%0d_dataout", c-2), int'(dataout), 81);
        chk($sformatf("toggle%0d_valid", c-2), int'(out_valid), vpat[c-2]);
      end
      if (c < 3) drive(9, 9, vpat[c] != 0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
